exp_poisson_spike_gen: RTL and testbench

//  Consumes exponentially distributed samples from the upstream exp_prng_lut

---
 rtl/exp_poisson_spike_gen.sv | 78 +++++++
 tb/tb_exp_poisson_spike_gen.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/exp_poisson_spike_gen.sv
// exp_poisson_spike_gen: turns exponential samples into interval countdowns and emits a Poisson spike train.
module exp_poisson_spike_gen #(
  parameter int X_WID     = 16,
  parameter int SHIFT_WID = 4,
  parameter int CNT_WID   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [X_WID-1:0]     sample_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  input  logic                 enable_i,
  input  logic [SHIFT_WID-1:0] scale_i,
  input  logic                 clear_i,
  output logic                 event_o,
  output logic [CNT_WID-1:0]   event_count_o,
  output logic                 underrun_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COUNT} state_t;
  state_t state_q, state_d;
  logic [X_WID-1:0] buf_q, buf_d, cnt_q, cnt_d, shifted, interval;
  logic [CNT_WID-1:0] count_q, count_d;
  logic buf_valid_q, buf_valid_d, event_q, event_d, underrun_q, underrun_d;
  logic term, reload_pt, consume, accept;
  assign shifted   = (32'(scale_i) >= X_WID) ? '0 : buf_q >> scale_i;
  assign interval  = (shifted == '0) ? X_WID'(1) : shifted;
  assign term      = (state_q == S_COUNT) && (cnt_q == X_WID'(1));
  assign reload_pt = (state_q == S_WAIT) || term;
  // ready depends only on registered state and enable, never on sample_valid_i
  assign consume        = enable_i & buf_valid_q & reload_pt;
  assign sample_ready_o = enable_i & (~buf_valid_q | reload_pt);
  assign accept         = sample_valid_i & sample_ready_o;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = accept ? sample_i : buf_q;
    buf_valid_d = accept | (buf_valid_q & ~consume);
    underrun_d  = clear_i ? 1'b0 : underrun_q;
    if (!enable_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_WAIT;
    end else if (consume) begin
      state_d = S_COUNT;
      cnt_d   = interval;
    end else if (term) begin
      state_d    = S_WAIT;
      underrun_d = 1'b1;
    end else if (state_q == S_COUNT) begin
      cnt_d = cnt_q - X_WID'(1);
    end
    event_d = enable_i & term;
    count_d = (clear_i ? '0 : count_q) + CNT_WID'(event_d);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      event_q     <= 1'b0;
      count_q     <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      event_q     <= event_d;
      count_q     <= count_d;
      underrun_q  <= underrun_d;
    end
  end
  assign event_o       = event_q;
  assign event_count_o = count_q;
  assign underrun_o    = underrun_q;
endmodule

// File: tb/tb_exp_poisson_spike_gen.sv
// tb_exp_poisson_spike_gen: table vectors, directed corner sequences and random stimulus against a deadline-based model.
module tb_exp_poisson_spike_gen;
  logic clk = 1'b0;
  logic rst_i, sample_valid_i, enable_i, clear_i;
  logic [15:0] sample_i;
  logic [3:0] scale_i;
  logic sample_ready_o, event_o, underrun_o, rdy4, ev4, und4;
  logic [15:0] event_count_o;
  logic [3:0] cnt4;
  always #5 clk = ~clk;
  exp_poisson_spike_gen dut (
    .clk_i(clk), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o), .enable_i(enable_i), .scale_i(scale_i), .clear_i(clear_i),
    .event_o(event_o), .event_count_o(event_count_o), .underrun_o(underrun_o));
  exp_poisson_spike_gen #(.CNT_WID(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(rdy4), .enable_i(enable_i), .scale_i(scale_i), .clear_i(clear_i),
    .event_o(ev4), .event_count_o(cnt4), .underrun_o(und4));
  int pass_n = 0, total_n = 0;
  int m_mode, m_cnt;
  int m_buf[$];
  longint m_t, m_dl;
  bit m_und, rdy_pre;
  typedef struct { bit en; bit v; int s; int sc; bit clr; bit ev; int cnt; bit und; bit rdy; } vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  function automatic longint ival(input int s, input int sc);
    int r;
    r = (sc >= 16) ? 0 : (s >> sc);
    return (r == 0) ? 1 : r;
  endfunction
  task automatic do_reset();
    rst_i = 1; enable_i = 1; sample_valid_i = 0; sample_i = 0; scale_i = 0; clear_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    m_mode = 0; m_buf.delete(); m_cnt = 0; m_und = 0; m_t = 0; m_dl = 0;
  endtask
  // model: mode 0 idle, 1 waiting for a sample, 2 counting toward absolute deadline m_dl
  task automatic step(input bit en, input bit v, input int s, input int sc, input bit clr);
    bit rdy_exp, ev;
    enable_i = en; sample_valid_i = v; sample_i = 16'(s); scale_i = 4'(sc); clear_i = clr;
    #1;
    rdy_exp = en && (m_buf.size() == 0 || m_mode == 1 || (m_mode == 2 && m_dl == m_t));
    rdy_pre = sample_ready_o;
    chk("ready", rdy_pre, rdy_exp);
    @(posedge clk);
    #1;
    ev = 0;
    if (clr) begin m_cnt = 0; m_und = 0; end
    if (!en) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && m_buf.size() != 0) begin
      m_dl = m_t + ival(m_buf.pop_front(), sc);
      m_mode = 2;
    end else if (m_mode == 2 && m_dl == m_t) begin
      ev = 1;
      if (m_buf.size() != 0) m_dl = m_t + ival(m_buf.pop_front(), sc);
      else begin m_und = 1; m_mode = 1; end
    end
    if (rdy_exp && v) m_buf.push_back(s);
    if (ev) m_cnt = (m_cnt + 1) % 65536;
    m_t++;
    chk("event", event_o, ev);
    chk("count", event_count_o, m_cnt);
    chk("count4", cnt4, m_cnt % 16);
    chk("underrun", underrun_o, m_und);
  endtask
  initial begin
    int first, last, n;
    tbl[0]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 5,      0,  0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[4]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[5]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0,      0,  0, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 0,      0,  0, 1, 1, 1, 1};
    tbl[8]  = '{1, 0, 0,      0,  0, 0, 1, 1, 1};
    tbl[9]  = '{1, 1, 0,      0,  0, 0, 1, 1, 1};
    tbl[10] = '{1, 1, 'h40,   8,  0, 0, 1, 1, 1};
    tbl[11] = '{1, 1, 'hFFFF, 8,  0, 1, 2, 1, 1};
    tbl[12] = '{1, 0, 0,      15, 0, 1, 3, 1, 1};
    tbl[13] = '{1, 0, 0,      15, 0, 1, 4, 1, 1};
    tbl[14] = '{1, 0, 0,      0,  0, 0, 4, 1, 1};
    tbl[15] = '{1, 0, 0,      0,  1, 0, 0, 0, 1};
    do_reset();
    #1;
    chk("rst_event", event_o, 0);
    chk("rst_count", event_count_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_ready", sample_ready_o, 1);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].s, tbl[i].sc, tbl[i].clr);
      chk($sformatf("tbl%0d_rdy", i), rdy_pre, tbl[i].rdy);
      chk($sformatf("tbl%0d_ev", i), event_o, tbl[i].ev);
      chk($sformatf("tbl%0d_cnt", i), event_count_o, tbl[i].cnt);
      chk($sformatf("tbl%0d_und", i), underrun_o, tbl[i].und);
    end
    do_reset();
    last = -1; n = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 3, 0, 0);
      if (event_o) begin
        chk("stream_reload_rdy", rdy_pre, 1);
        if (last >= 0) chk("stream_gap", i - last, 3);
        last = i; n++;
      end
    end
    chk("stream_events", n, 12);
    chk("stream_underrun", underrun_o, 0);
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 1, 10, 0, 0);
    step(1, 1, 7, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 99, 0, 0);
      chk("drop_rdy", rdy_pre, 0);
      chk("drop_ev", event_o, 0);
    end
    first = -1;
    for (int j = 0; j < 12; j++) begin
      step(1, 0, 0, 0, 0);
      if (event_o && first < 0) first = j;
    end
    chk("reenable_first_event", first, 8);
    chk("reenable_count", event_count_o, 1);
    do_reset();
    for (int i = 0; i < 19; i++) step(1, 1, 1, 0, 0);
    chk("wrap_count16", event_count_o, 17);
    chk("wrap_count4", cnt4, 1);
    step(1, 1, 1, 0, 1);
    chk("clear_event_ev", event_o, 1);
    chk("clear_event_count", event_count_o, 1);
    chk("clear_event_count4", cnt4, 1);
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      int s, sc;
      sc = $urandom_range(0, 15);
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 12);
      if (s > 12 && sc < 12) sc = 12;
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0, s, sc, $urandom_range(0, 39) == 0);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
